wb_write_queue: RTL and testbench
=================================

# wb_write_queue

Writeback-side producer for the 32-entry register file's single write port. Accepts completed results from the ALU path and the load path through valid/ready handshakes and buffers them in an in-order queue. Drains one entry per cycle onto the register file's write port (address, data, enable), which the register file samples on the falling clock edge. Exposes a pending-write lookup with youngest-match data so decode can stall or bypass against queued results.

## Interface
- N, 32, data width; must equal register file width
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock; queue state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted this rising edge when ld_valid=1
- ld_rd  in  5  load destination register
- ld_data  in  N  load result
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this rising edge when alu_valid=1
- alu_rd  in  5  ALU destination register
- alu_data  in  N  ALU result
- wr_en  out  1  drives register file write enable
- wr_addr  out  5  drives register file write address
- wr_data  out  N  drives register file write data
- q_rs1, q_rs2  in  5 each  lookup addresses from decode
- rs1_pending, rs2_pending  out  1 each  queued write to that register exists
- rs1_fwd, rs2_fwd  out  N each  data of youngest matching queued entry
- count  out  $clog2(DEPTH)+1  occupied entries
- empty, full  out  1 each  count==0 / count==DEPTH

## Operation
- Circular buffer of {rd, data}: head pointer, tail pointer, count.
- Head drives write port combinationally: wr_en=!empty, wr_addr/wr_data=head entry; all zero when empty.
- Pop: every rising edge with !empty; the register file always accepts.
- free = DEPTH − count + (count≠0 ? 1 : 0) (slot freed by this cycle's pop is reusable).
- ld_ready = free≥1. alu_ready = free≥2, or free≥1 and ld_valid=0. Load has priority.
- Both accepted in the same edge: load entry written at tail, ALU entry at tail+1 (load is older).
- Handshake with rd=0: accepted (ready obeys the normal rule), not stored; count and tail unaffected by it.
- count_next = count − pop + accepted non-x0 entries.
- Lookup: rsX_pending=1 iff q_rsX≠0 and some occupied entry has rd==q_rsX. rsX_fwd=data of the youngest such entry (closest to tail), 0 when not pending. Purely combinational over current contents; results enqueued in the same cycle are not visible.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (async assert): head=tail=count=0. empty=1, full=0, wr_en=0, wr_addr=0, wr_data=0, pending=0, fwd=0. While rst=1, ld_ready=alu_ready=0. Entry contents are don't-care.
- Latency: result accepted at rising edge k appears on wr_* in cycle k..k+1, is written by the register file at the intervening falling edge, and is popped at edge k+1 if it is head.
- Throughput: 1 write per cycle sustained; 2 enqueues per cycle accepted only while backlog fits.
- Full with pop: free=1, so only one producer is accepted (load if valid).
- Reset mid-operation discards all queued entries. In-flight handshakes in that cycle are not accepted.
- Ready outputs never depend on their own valid.

## Structure
- Shared package/header wb_defs: REG_ADDR_W=5, entry field layout, and the x0 constant, reused by decode and hazard logic.
- One sub-module, wb_match: a parameterized youngest-first search over occupied entries returning {hit, data}. Instantiated twice, for rs1 and rs2.

## Test plan
- Reset check: with rst=1 and both producers valid -> readys=0, wr_en=0, count=0. After release, a single ld (rd=5, data=0xA5A5A5A5) -> wr_en=1, wr_addr=5, wr_data=0xA5A5A5A5 in the next cycle, then empty.
- Dual accept: ld (rd=3, 0x11) and alu (rd=4, 0x22) in the same cycle -> write port shows rd 3, then rd 4 on consecutive cycles; count goes 2→1→0.
- Backpressure: both producers valid every cycle with distinct rd -> count reaches DEPTH and holds. When full, ld accepted and alu_ready=0; writes stay in order with no loss or duplication.
- x0 drop: alu (rd=0, 0xDEAD) -> alu_ready=1, count unchanged, wr_en never asserted for rd 0. A lookup of q_rs1=0 -> pending=0.
- Youngest forward: queue rd=7 with 0x1 then rd=7 with 0x2, q_rs2=7 -> rs2_pending=1, rs2_fwd=0x2. After the first pop -> still 0x2. After the second pop -> pending=0.
- Async reset mid-stream: assert rst between clock edges with 3 entries queued -> count=0 and wr_en=0 immediately. No further writes after release until a new handshake.

Source files
------------

// File: rtl/wb_defs_pkg.sv
// Writeback definitions shared by the write queue, decode and hazard logic.
// A queue entry is {rd, data}; rd is REG_ADDR_W wide, data is the register file width.
package wb_defs;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t X0 = '0;

    function automatic logic is_x0(input reg_addr_t a);
        return a == X0;
    endfunction

endpackage

// File: rtl/wb_match.sv
// Youngest-first search of the occupied queue entries for a destination register.
// Walks entries oldest to youngest so the last hit (closest to tail) wins.
module wb_match
    import wb_defs::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  reg_addr_t                          q,
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_rd,
    input  logic [DEPTH-1:0][N-1:0]            ent_data,
    input  logic [AW-1:0]                      head,
    input  logic [CW-1:0]                      count,
    output logic                               hit,
    output logic [N-1:0]                       data
);

    logic [AW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if ((CW'(i) < count) && (ent_rd[idx] == q) && !is_x0(q)) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the register file write port from the load and ALU paths,
// with pending-write lookup and youngest-entry forwarding for decode.
module wb_write_queue
    import wb_defs::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [N-1:0]          ld_data,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [N-1:0]          alu_data,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [N-1:0]          wr_data,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    output logic                  rs1_pending,
    output logic                  rs2_pending,
    output logic [N-1:0]          rs1_fwd,
    output logic [N-1:0]          rs2_fwd,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full
);

    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
    logic [DEPTH-1:0][N-1:0]          ent_data;
    logic [AW-1:0]                    head, tail, alu_idx;
    logic [CW-1:0]                    free;
    logic                             pop, ld_store, alu_store;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = !empty;

    // The head slot is vacated this edge, so it counts as free for an incoming result.
    assign free      = CW'(DEPTH) - count + CW'(pop);
    assign ld_ready  = !rst && (free != '0);
    assign alu_ready = !rst && ((free >= CW'(2)) || ((free != '0) && !ld_valid));

    assign ld_store  = ld_valid && ld_ready && !is_x0(ld_rd);
    assign alu_store = alu_valid && alu_ready && !is_x0(alu_rd);
    assign alu_idx   = tail + AW'(ld_store);

    assign wr_en   = pop;
    assign wr_addr = pop ? ent_rd[head]   : '0;
    assign wr_data = pop ? ent_data[head] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop);
            tail  <= tail + AW'(ld_store) + AW'(alu_store);
            count <= count - CW'(pop) + CW'(ld_store) + CW'(alu_store);
        end
    end

    // Entry storage needs no reset: only slots inside [head, head+count) are ever observed.
    always_ff @(posedge clk) begin
        if (ld_store) begin
            ent_rd[tail]   <= ld_rd;
            ent_data[tail] <= ld_data;
        end
        if (alu_store) begin
            ent_rd[alu_idx]   <= alu_rd;
            ent_data[alu_idx] <= alu_data;
        end
    end

    logic [1:0][REG_ADDR_W-1:0] q_rs;
    logic [1:0]                 hit;
    logic [1:0][N-1:0]          fwd;

    assign q_rs = {q_rs2, q_rs1};

    for (genvar g = 0; g < 2; g++) begin : g_match
        wb_match #(.N(N), .DEPTH(DEPTH)) u_match (
            .q        (q_rs[g]),
            .ent_rd   (ent_rd),
            .ent_data (ent_data),
            .head     (head),
            .count    (count),
            .hit      (hit[g]),
            .data     (fwd[g])
        );
    end

    assign rs1_pending = hit[0];
    assign rs2_pending = hit[1];
    assign rs1_fwd     = fwd[0];
    assign rs2_fwd     = fwd[1];

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: accepted results are queued as expected writes and a
// negedge monitor compares them against the register file write port in order.
module tb_wb_write_queue;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, alu_valid;
    logic          ld_ready, alu_ready;
    logic [4:0]    ld_rd, alu_rd;
    logic [N-1:0]  ld_data, alu_data;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [N-1:0]  wr_data;
    logic [4:0]    q_rs1, q_rs2;
    logic          rs1_pending, rs2_pending;
    logic [N-1:0]  rs1_fwd, rs2_fwd;
    logic [CW-1:0] count;
    logic          empty, full;

    always #5 clk = ~clk;

    wb_write_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .q_rs1(q_rs1), .q_rs2(q_rs2),
        .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
        .count(count), .empty(empty), .full(full)
    );

    int tests = 0;
    int fails = 0;
    int mcount = 0;
    logic [36:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the register file sees must be the oldest outstanding result.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (sb.size() == 0) begin
                chk("spurious_write", {27'd0, wr_addr, wr_data}, 64'd0);
            end else begin
                chk("write_port", {27'd0, wr_addr, wr_data}, {27'd0, sb[0]});
                void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus starting at posedge+1; readys are checked against a count model.
    task automatic drive(input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad);
        int  free;
        logic exp_lr, exp_ar, lacc, aacc;
        ld_valid = lv; ld_rd = lr; ld_data = ldd;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        #1;
        free   = DEPTH - mcount + ((mcount != 0) ? 1 : 0);
        exp_lr = (free >= 1);
        exp_ar = (free >= 2) || ((free >= 1) && !lv);
        chk("ld_ready", ld_ready, exp_lr);
        chk("alu_ready", alu_ready, exp_ar);
        lacc = lv && exp_lr;
        aacc = av && exp_ar;
        mcount = mcount - ((mcount != 0) ? 1 : 0) + ((lacc && lr != 0) ? 1 : 0)
                 + ((aacc && ar != 0) ? 1 : 0);
        @(posedge clk);
        if (lacc && lr != 0) sb.push_back({lr, ldd});
        if (aacc && ar != 0) sb.push_back({ar, ad});
        #1;
        chk("count", count, mcount);
        chk("empty", empty, mcount == 0);
        chk("full", full, mcount == DEPTH);
        ld_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h1;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
        q_rs1 = 5'd1; q_rs2 = 5'd2;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 5'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_pending", {rs1_pending, rs2_pending}, 2'b00);
        chk("rst_fwd", {rs1_fwd, rs2_fwd}, 64'd0);
        rst = 1'b0;
        ld_valid = 1'b0; alu_valid = 1'b0;

        // Single load reaches the write port the cycle after acceptance.
        drive(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
        chk("single_wr_en", wr_en, 1'b1);
        chk("single_wr_addr", wr_addr, 5'd5);
        chk("single_wr_data", wr_data, 32'hA5A5A5A5);
        idle(1);
        chk("single_drained", wr_en, 1'b0);

        // Dual accept: load is older than ALU.
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        chk("dual_head", wr_addr, 5'd3);
        idle(1);
        chk("dual_second", wr_addr, 5'd4);
        idle(1);

        // Backpressure: both producers every cycle; count climbs to DEPTH and holds.
        for (int i = 0; i < 8; i++)
            drive(1'b1, 5'(8 + i), 32'h100 + 32'(i), 1'b1, 5'(20 + i), 32'h200 + 32'(i));
        chk("bp_full_alu_ready_low", alu_ready, 1'b0);
        idle(DEPTH + 1);

        // x0 results are accepted but never stored.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        chk("x0_wr_en", wr_en, 1'b0);
        q_rs1 = 5'd0;
        #1;
        chk("x0_lookup", rs1_pending, 1'b0);

        // Youngest of two rd=7 entries is forwarded.
        q_rs1 = 5'd4; q_rs2 = 5'd7;
        drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
        chk("fwd_pending", rs2_pending, 1'b1);
        chk("fwd_data", rs2_fwd, 32'h2);
        chk("fwd_nomatch", {rs1_pending, rs1_fwd}, 33'd0);
        idle(1);
        chk("fwd_pending_pop1", rs2_pending, 1'b1);
        chk("fwd_data_pop1", rs2_fwd, 32'h2);
        idle(1);
        chk("fwd_pending_pop2", rs2_pending, 1'b0);
        chk("fwd_data_pop2", rs2_fwd, 32'h0);

        // Async reset with three entries queued.
        drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA);
        drive(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC);
        chk("pre_rst_count", count, 3);
        #2;
        rst = 1'b1;
        ld_valid = 1'b1; ld_rd = 5'd13; alu_valid = 1'b1; alu_rd = 5'd14;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_wr_en", wr_en, 1'b0);
        chk("async_rst_readys", {ld_ready, alu_ready}, 2'b00);
        sb.delete();
        mcount = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ld_valid = 1'b0; alu_valid = 1'b0;
        idle(3);
        chk("post_rst_quiet", wr_en, 1'b0);
        drive(1'b1, 5'd13, 32'hD, 1'b0, 5'd0, 32'd0);
        chk("post_rst_write", {wr_en, wr_addr}, {1'b1, 5'd13});
        idle(2);

        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
